// File: rtl/drate_mc_if.sv
// drate_mc_if -- handshake and data bundle for the drate_mc decimating FIR.
//   master : frame source / control side (drives in_valid, in_data, coefs,
//            dec, clr_ovf; observes in_ready, out_valid, out_data, ovf)
//   slave  : the filter itself
// Channel c of in_data/out_data lives at [c*W +: W]; tap k of coefs at
// [k*CW +: CW]. All samples and coefficients are two's complement.
interface drate_mc_if #(
  parameter int CH   = 2,
  parameter int W    = 16,
  parameter int TAPS = 64,
  parameter int CW   = 16,
  parameter int DMAX = 32
);
  localparam int DW = $clog2(DMAX + 1);

  logic                 in_valid;
  logic                 in_ready;
  logic [CH*W-1:0]      in_data;
  logic [TAPS*CW-1:0]   coefs;
  logic [DW-1:0]        dec;
  logic                 out_valid;
  logic [CH*W-1:0]      out_data;
  logic                 clr_ovf;
  logic [CH-1:0]        ovf;

  modport master (
    output in_valid, in_data, coefs, dec, clr_ovf,
    input  in_ready, out_valid, out_data, ovf
  );

  modport slave (
    input  in_valid, in_data, coefs, dec, clr_ovf,
    output in_ready, out_valid, out_data, ovf
  );
endinterface

// File: rtl/drate_mc.sv
// drate_mc -- multichannel decimating FIR with one serial MAC per channel.
//   clk       : sole clock, rising edge
//   rst       : asynchronous active-high reset
//   bus       : drate_mc_if.slave
//     in_valid/in_ready : frame handshake (accept when both high)
//     in_data           : CH signed samples
//     coefs             : TAPS signed coefficients shared by all channels
//     dec               : decimation ratio (0 -> 1, >DMAX -> DMAX)
//     out_valid         : one-cycle strobe for a new out_data
//     out_data          : CH rounded/saturated outputs, held until next strobe
//     clr_ovf / ovf     : sticky per-channel saturation flags and their clear
// Every accepted frame shifts the delay lines. The frame that closes a
// decimation period starts a TAPS-cycle MAC pass (input stalled), followed by
// one cycle in OUT; the rounded result is registered on leaving OUT.
module drate_mc #(
  parameter int CH    = 2,
  parameter int W     = 16,
  parameter int TAPS  = 64,
  parameter int CW    = 16,
  parameter int DMAX  = 32,
  parameter int SLICE = 15
) (
  input  logic        clk,
  input  logic        rst,
  drate_mc_if.slave   bus
);
  localparam int DW = $clog2(DMAX + 1);
  localparam int KW = (TAPS > 1) ? $clog2(TAPS) : 1;
  localparam int PW = W + CW;
  localparam int AW = W + CW + $clog2(TAPS);

  // Rounding constant: half an output LSB, none when nothing is sliced off.
  localparam logic signed [AW:0] RND =
    (SLICE > 0) ? ((AW + 1)'(1) << ((SLICE > 0) ? (SLICE - 1) : 0)) : '0;
  localparam logic signed [AW:0] SAT_HI = {{(AW - W + 2){1'b0}}, {(W - 1){1'b1}}};
  localparam logic signed [AW:0] SAT_LO = {{(AW - W + 2){1'b1}}, {(W - 1){1'b0}}};

  typedef enum logic [1:0] {S_IDLE, S_MAC, S_OUT} state_t;

  state_t          state_q;
  logic [DW-1:0]   phase_q;
  logic [DW-1:0]   d_q;
  logic [KW-1:0]   k_q;
  logic            in_ready_q;
  logic            out_valid_q;

  logic [DW-1:0]   dec_clamped;
  logic [DW-1:0]   d_eff;
  logic            accept;
  logic            last_frame;
  logic            mac_start;

  logic signed [CW-1:0] coef_arr [TAPS];

  genvar gi;
  generate
    for (gi = 0; gi < TAPS; gi++) begin : g_coef
      assign coef_arr[gi] = bus.coefs[gi*CW +: CW];
    end
  endgenerate

  assign accept = bus.in_valid & in_ready_q;

  always_comb begin
    dec_clamped = bus.dec;
    if (bus.dec == '0) begin
      dec_clamped = DW'(1);
    end else if (bus.dec > DW'(DMAX)) begin
      dec_clamped = DW'(DMAX);
    end
  end

  // The ratio is only re-sampled on the first frame of a period, so the
  // end-of-period test must use the fresh value for that frame.
  assign d_eff      = (phase_q == '0) ? dec_clamped : d_q;
  assign last_frame = (phase_q == d_eff - DW'(1));
  assign mac_start  = accept & last_frame;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      phase_q     <= '0;
      d_q         <= DW'(1);
      k_q         <= '0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      out_valid_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          in_ready_q <= 1'b1;
          if (accept) begin
            if (phase_q == '0) begin
              d_q <= dec_clamped;
            end
            if (last_frame) begin
              phase_q    <= '0;
              k_q        <= '0;
              state_q    <= S_MAC;
              in_ready_q <= 1'b0;
            end else begin
              phase_q <= phase_q + 1'b1;
            end
          end
        end
        S_MAC: begin
          if (k_q == KW'(TAPS - 1)) begin
            state_q <= S_OUT;
          end
          k_q <= k_q + 1'b1;
        end
        S_OUT: begin
          // The output register loads on this same edge (see channel block).
          state_q     <= S_IDLE;
          out_valid_q <= 1'b1;
          in_ready_q  <= 1'b1;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;

  generate
    for (gi = 0; gi < CH; gi++) begin : g_ch
      logic signed [W-1:0]  line_q [TAPS];
      logic signed [W-1:0]  line_d [TAPS];
      logic signed [AW-1:0] acc_q;
      logic signed [AW-1:0] acc_d;
      logic signed [W-1:0]  out_q;
      logic signed [W-1:0]  out_d;
      logic                 ovf_q;
      logic                 ovf_d;
      logic signed [PW-1:0] prod;
      logic signed [AW:0]   rounded;
      logic signed [AW:0]   shifted;
      logic signed [W-1:0]  sat_val;
      logic                 sat_hit;

      always_comb begin
        line_d = line_q;
        if (accept) begin
          line_d[0] = bus.in_data[gi*W +: W];
          for (int t = 1; t < TAPS; t++) begin
            line_d[t] = line_q[t-1];
          end
        end
      end

      // Coefficients are read live from the bus; the source holds them
      // stable while the filter is busy.
      assign prod = coef_arr[k_q] * line_q[k_q];

      always_comb begin
        acc_d = acc_q;
        if (mac_start) begin
          acc_d = '0;
        end else if (state_q == S_MAC) begin
          acc_d = acc_q + AW'(prod);
        end
      end

      // One guard bit above the accumulator so the rounding add never wraps.
      assign rounded = {acc_q[AW-1], acc_q} + RND;
      assign shifted = rounded >>> SLICE;

      always_comb begin
        sat_val = shifted[W-1:0];
        sat_hit = 1'b0;
        if (shifted > SAT_HI) begin
          sat_val = SAT_HI[W-1:0];
          sat_hit = 1'b1;
        end else if (shifted < SAT_LO) begin
          sat_val = SAT_LO[W-1:0];
          sat_hit = 1'b1;
        end
      end

      always_comb begin
        out_d = out_q;
        if (state_q == S_OUT) begin
          out_d = sat_val;
        end
      end

      // A clip in the same cycle as a clear leaves the flag set.
      assign ovf_d = (bus.clr_ovf ? 1'b0 : ovf_q) | ((state_q == S_OUT) & sat_hit);

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          line_q <= '{default: '0};
          acc_q  <= '0;
          out_q  <= '0;
          ovf_q  <= 1'b0;
        end else begin
          line_q <= line_d;
          acc_q  <= acc_d;
          out_q  <= out_d;
          ovf_q  <= ovf_d;
        end
      end

      assign bus.out_data[gi*W +: W] = out_q;
      assign bus.ovf[gi]             = ovf_q;
    end
  endgenerate
endmodule

// File: tb/tb_drate_mc.sv
// tb_drate_mc -- directed bench for drate_mc. Two instances run in lockstep
// on the same stimulus: u_dut_a with SLICE=0 (impulse response visible
// directly) and u_dut_b with default parameters.
module tb_drate_mc;
  localparam int TAPS = 64;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic [31:0]   in_data;
  logic [TAPS*16-1:0] coefs;
  logic [5:0]    dec;
  logic          clr_ovf;

  int n_checks = 0;
  int n_errors = 0;

  logic [31:0] qa[$];
  logic [31:0] qb[$];

  drate_mc_if ifa ();
  drate_mc_if ifb ();

  assign ifa.in_valid = in_valid;
  assign ifa.in_data  = in_data;
  assign ifa.coefs    = coefs;
  assign ifa.dec      = dec;
  assign ifa.clr_ovf  = clr_ovf;
  assign ifb.in_valid = in_valid;
  assign ifb.in_data  = in_data;
  assign ifb.coefs    = coefs;
  assign ifb.dec      = dec;
  assign ifb.clr_ovf  = clr_ovf;

  drate_mc #(.SLICE(0)) u_dut_a (.clk(clk), .rst(rst), .bus(ifa));
  drate_mc              u_dut_b (.clk(clk), .rst(rst), .bus(ifb));

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (ifa.out_valid) qa.push_back(ifa.out_data);
    if (ifb.out_valid) qb.push_back(ifb.out_data);
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_ready();
    int n = 0;
    while (!ifb.in_ready && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (!ifb.in_ready) check("ready_timeout", ifb.in_ready, 1);
  endtask

  task automatic send_frame(input logic [15:0] c0, input logic [15:0] c1);
    wait_ready();
    $display("frame ch0=%0d ch1=%0d dec=%0d", $signed(c0), $signed(c1), dec);
    in_data  = {c1, c0};
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic settle();
    wait_ready();
    @(negedge clk);
  endtask

  task automatic run_impulse(input string tag);
    for (int k = 0; k < TAPS; k++) coefs[k*16 +: 16] = 16'(k + 1);
    dec = 6'd1;
    qa.delete();
    for (int i = 0; i <= TAPS; i++) send_frame((i == 0) ? 16'd1 : 16'd0, 16'd0);
    settle();
    check({tag, "_count"}, qa.size(), TAPS + 1);
    for (int i = 0; i < qa.size() && i <= TAPS; i++) begin
      check({tag, "_ch0"}, qa[i][15:0], (i < TAPS) ? 16'(i + 1) : 16'd0);
      check({tag, "_ch1"}, qa[i][31:16], 16'd0);
    end
  endtask

  initial begin
    int n;
    rst = 1'b1; in_valid = 1'b0; in_data = '0; coefs = '0; dec = 6'd1; clr_ovf = 1'b0;

    // Reset values
    repeat (3) @(negedge clk);
    check("rst_ready", ifb.in_ready, 0);
    check("rst_valid", ifb.out_valid, 0);
    check("rst_data", ifb.out_data, 0);
    check("rst_ovf", ifb.ovf, 0);
    rst = 1'b0;
    @(negedge clk);
    check("rel_ready", ifb.in_ready, 1);

    // Impulse response, SLICE=0
    run_impulse("imp1");

    // Reset 10 cycles into MAC: no output, then identical impulse response
    qa.delete(); qb.delete();
    send_frame(16'd1, 16'd0);
    repeat (10) @(negedge clk);
    check("mid_mac_busy", ifa.in_ready, 0);
    rst = 1'b1;
    @(negedge clk);
    check("mid_rst_ready", ifa.in_ready, 0);
    check("mid_rst_data", ifa.out_data, 0);
    rst = 1'b0;
    @(negedge clk);
    check("mid_rel_ready", ifa.in_ready, 1);
    repeat (80) @(negedge clk);
    check("mid_no_out", qa.size() + qb.size(), 0);
    run_impulse("imp2");

    // DC, dec=4, coefs 512
    for (int k = 0; k < TAPS; k++) coefs[k*16 +: 16] = 16'd512;
    dec = 6'd4;
    qb.delete();
    for (int i = 0; i < 72; i++) send_frame(16'd1000, 16'hFC18);
    settle();
    check("dc_count", qb.size(), 18);
    if (qb.size() == 18) begin
      check("dc_first_ch0", qb[0][15:0], 16'd63);
      check("dc_first_ch1", qb[0][31:16], 16'hFFC2);
      for (int i = 15; i < 18; i++) begin
        check("dc_ch0", qb[i][15:0], 16'd1000);
        check("dc_ch1", qb[i][31:16], 16'hFC18);
      end
    end
    check("dc_ovf", ifb.ovf, 0);

    // Saturation and sticky flags
    for (int k = 0; k < TAPS; k++) coefs[k*16 +: 16] = 16'd32767;
    dec = 6'd1;
    send_frame(16'h7FFF, 16'h8000);
    settle();
    check("sat_ch0", ifb.out_data[15:0], 16'h7FFF);
    check("sat_ch1", ifb.out_data[31:16], 16'h8000);
    check("sat_ovf", ifb.ovf, 2'b11);
    coefs = '0;
    send_frame(16'd0, 16'd0);
    settle();
    check("zero_out", ifb.out_data, 0);
    check("ovf_sticky", ifb.ovf, 2'b11);
    clr_ovf = 1'b1;
    @(negedge clk);
    clr_ovf = 1'b0;
    check("ovf_cleared", ifb.ovf, 0);

    // Clear and saturation in the same cycle: saturation wins
    for (int k = 0; k < TAPS; k++) coefs[k*16 +: 16] = 16'd32767;
    clr_ovf = 1'b1;
    send_frame(16'h7FFF, 16'h8000);
    n = 0;
    while (!ifb.out_valid && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("satwin_valid", ifb.out_valid, 1);
    check("satwin_ovf", ifb.ovf, 2'b11);
    clr_ovf = 1'b0;
    @(negedge clk);
    check("satwin_hold", ifb.ovf, 2'b11);

    // Handshake, in_valid held high, dec=3
    coefs = '0;
    dec = 6'd3;
    in_data = '0;
    in_valid = 1'b1;
    repeat (3) @(negedge clk);
    n = 0;
    while (!ifb.in_ready && n < 200) begin
      n++;
      @(negedge clk);
    end
    in_valid = 1'b0;
    $display("handshake: in_ready low for %0d cycles", n);
    check("hs_low_cycles", n, 65);
    check("hs_valid", ifb.out_valid, 1);
    @(negedge clk);
    check("hs_valid_single", ifb.out_valid, 0);
    check("hs_ready_after", ifb.in_ready, 1);

    // Ratio change 2 -> 5 mid-period
    dec = 6'd2;
    send_frame(16'd0, 16'd0);
    check("ratio_p1_ready", ifb.in_ready, 1);
    dec = 6'd5;
    send_frame(16'd0, 16'd0);
    check("ratio_p2_end", ifb.in_ready, 0);
    for (int i = 0; i < 4; i++) begin
      send_frame(16'd0, 16'd0);
      check("ratio5_open", ifb.in_ready, 1);
    end
    send_frame(16'd0, 16'd0);
    check("ratio5_end", ifb.in_ready, 0);
    settle();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
